// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the frame-buffer RAM between VGA scan-out (fixed priority) and the CPU,
// and applies the double-buffered colour configuration on VS falling edges.
module vga_fb_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 1,
  parameter logic [15:0] CFG_RESET = 16'hFF00,
  parameter int STARVE_MAX = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VGA_REQ,
  input  logic [ADDR_W-1:0] VGA_ADDR,
  input  logic              VGA_VS,
  output logic [DATA_W-1:0] VGA_DATA,
  output logic              VGA_VALID,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_ACK,
  input  logic              CFG_WE,
  input  logic [15:0]       CFG_DATA,
  output logic [15:0]       CONFIG_COLOURS,
  output logic              CFG_PENDING,
  output logic              STARVED,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);
  typedef enum logic [1:0] {C_IDLE, C_WR_ACK, C_RD_WAIT, C_RD_ACK} cpu_st_t;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  cpu_st_t cst_q, cst_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic vga_t1_q, vga_t1_d, vga_t2_q, vga_t2_d;
  logic vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [CW-1:0] wait_q, wait_d;
  logic starved_q, starved_d;
  logic vs_q, vs_d;
  logic [15:0] pend_q, pend_d, colours_q, colours_d;
  logic cfg_pend_q, cfg_pend_d;
  logic cpu_idle, cpu_gnt, vs_fall;
  always_comb begin
    // The ACK cycle counts as busy so a still-held CPU_REQ is not re-granted.
    cpu_idle = cst_q == C_IDLE && !cpu_ack_q;
    cpu_gnt = !VGA_REQ && cpu_idle && CPU_REQ;
    mem_addr_d = VGA_REQ ? VGA_ADDR : cpu_gnt ? CPU_ADDR : mem_addr_q;
    mem_we_d = cpu_gnt && CPU_WE;
    mem_wdata_d = cpu_gnt ? CPU_WDATA : mem_wdata_q;
    vga_t1_d = VGA_REQ;
    vga_t2_d = vga_t1_q;
    vga_valid_d = vga_t2_q;
    vga_data_d = vga_t2_q ? MEM_RDATA : vga_data_q;
    cst_d = cpu_gnt ? (CPU_WE ? C_WR_ACK : C_RD_WAIT) : cst_q == C_RD_WAIT ? C_RD_ACK : C_IDLE;
    cpu_ack_d = cst_q == C_WR_ACK || cst_q == C_RD_ACK;
    cpu_rdata_d = cst_q == C_RD_ACK ? MEM_RDATA : cpu_rdata_q;
    wait_d = cpu_gnt ? '0 : (cpu_idle && CPU_REQ && wait_q != SMAX) ? wait_q + 1'b1 : wait_q;
    starved_d = starved_q || wait_d == SMAX;
    vs_d = VGA_VS;
    vs_fall = vs_q && !VGA_VS;
    pend_d = CFG_WE ? CFG_DATA : pend_q;
    colours_d = vs_fall ? (CFG_WE ? CFG_DATA : cfg_pend_q ? pend_q : colours_q) : colours_q;
    cfg_pend_d = vs_fall ? 1'b0 : CFG_WE ? 1'b1 : cfg_pend_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cst_q <= C_IDLE;
      mem_addr_q <= '0;
      mem_we_q <= 1'b0;
      mem_wdata_q <= '0;
      vga_t1_q <= 1'b0;
      vga_t2_q <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_data_q <= '0;
      cpu_ack_q <= 1'b0;
      cpu_rdata_q <= '0;
      wait_q <= '0;
      starved_q <= 1'b0;
      vs_q <= 1'b1;
      pend_q <= CFG_RESET;
      colours_q <= CFG_RESET;
      cfg_pend_q <= 1'b0;
    end else begin
      cst_q <= cst_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vga_t1_q <= vga_t1_d;
      vga_t2_q <= vga_t2_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q <= vga_data_d;
      cpu_ack_q <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      wait_q <= wait_d;
      starved_q <= starved_d;
      vs_q <= vs_d;
      pend_q <= pend_d;
      colours_q <= colours_d;
      cfg_pend_q <= cfg_pend_d;
    end
  end
  assign MEM_ADDR = mem_addr_q;
  assign MEM_WE = mem_we_q;
  assign MEM_WDATA = mem_wdata_q;
  assign VGA_VALID = vga_valid_q;
  assign VGA_DATA = vga_data_q;
  assign CPU_ACK = cpu_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign STARVED = starved_q;
  assign CONFIG_COLOURS = colours_q;
  assign CFG_PENDING = cfg_pend_q;
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares the single-port frame-buffer RAM between the VGA scan-out engine (real-time, fixed priority) and the microprocessor bus (CPU).
- Sequences RAM commands and routes synchronous read data back to the correct requester.
- Holds the colour configuration register, which is double-buffered and applied only at frame boundaries to avoid tearing.
- Sits between vga_wrapper, the bus interface and the frame-buffer BRAM.

Parameters:
- ADDR_W, 15, frame-buffer address width (160x120 = 19200 pixels).
- DATA_W, 1, pixel width.
- CFG_RESET, 16'hFF00, reset value of the colour configuration: [15:8] foreground, [7:0] background.
- STARVE_MAX, 64, number of consecutive CPU wait cycles before STARVED is raised.

Ports:
- CLK  in  1  system clock (100 MHz)
- RESET  in  1  synchronous, active-high reset
- VGA_REQ  in  1  scan-out pixel read request; one cycle per request
- VGA_ADDR  in  ADDR_W  scan-out pixel address
- VGA_VS  in  1  vertical sync, active-low; used for config latching
- VGA_DATA  out  DATA_W  pixel read data
- VGA_VALID  out  1  VGA_DATA valid pulse
- CPU_REQ  in  1  CPU access request; held high until CPU_ACK
- CPU_WE  in  1  1 = write, 0 = read; held with CPU_REQ
- CPU_ADDR  in  ADDR_W  CPU address
- CPU_WDATA  in  DATA_W  CPU write data
- CPU_RDATA  out  DATA_W  CPU read data, valid with CPU_ACK
- CPU_ACK  out  1  one-cycle completion pulse
- CFG_WE  in  1  write to the pending colour register
- CFG_DATA  in  16  colour configuration value
- CONFIG_COLOURS  out  16  active colour configuration, fed to vga_wrapper
- CFG_PENDING  out  1  pending value not yet applied
- STARVED  out  1  sticky: a CPU request waited STARVE_MAX cycles
- MEM_ADDR  out  ADDR_W  RAM address (registered)
- MEM_WE  out  1  RAM write enable (registered)
- MEM_WDATA  out  DATA_W  RAM write data (registered)
- MEM_RDATA  in  DATA_W  RAM read data; valid 1 cycle after the command is presented

Behaviour:
- Reset values (applied on any edge where RESET=1, mid-operation included):
  - MEM_WE, VGA_VALID, CPU_ACK, CFG_PENDING, STARVED = 0.
  - MEM_ADDR, MEM_WDATA, VGA_DATA, CPU_RDATA = 0.
  - CONFIG_COLOURS and the pending register = CFG_RESET.
  - CPU FSM = C_IDLE; wait counter = 0; VS history = 1.
  - Any in-flight read is discarded and no ACK or VALID is issued for it.
- Arbitration, evaluated at every edge E0:
  - VGA_REQ=1: issue a VGA read. MEM_ADDR<=VGA_ADDR, MEM_WE<=0. Tag pipeline records VGA.
  - Else if CPU FSM is C_IDLE and CPU_REQ=1: issue the CPU op. MEM_ADDR<=CPU_ADDR, MEM_WE<=CPU_WE, MEM_WDATA<=CPU_WDATA. Tag records CPU.
  - Else: MEM_WE<=0 and the tag records NONE.
- VGA latency:
  - Request sampled at E0 leads to VGA_VALID=1 with VGA_DATA=MEM_RDATA registered at E2.
  - Back-to-back VGA_REQ every cycle is fully pipelined: one VALID per request, in order.
- CPU FSM:
  - C_IDLE -> C_WR_ACK on a granted write. At E1, CPU_ACK=1 for one cycle; the write has already been presented to the RAM.
  - C_IDLE -> C_RD_WAIT on a granted read -> C_RD_ACK. At E2, CPU_ACK=1 and CPU_RDATA=MEM_RDATA.
  - C_WR_ACK / C_RD_ACK -> C_IDLE. CPU_REQ is ignored during the ACK cycle; a new request is accepted from the following edge.
  - Only one CPU operation is outstanding at a time. CPU_WE, CPU_ADDR and CPU_WDATA are sampled only at grant.
- Simultaneous VGA_REQ and CPU_REQ: VGA wins and the CPU waits. A CPU write and a following VGA read of the same address are serialised in grant order.
- Starvation:
  - Wait counter increments on each edge with CPU_REQ=1 in C_IDLE and no grant. It saturates at STARVE_MAX and clears on grant.
  - When the counter reaches STARVE_MAX, STARVED<=1. STARVED is cleared only by RESET.
  - STARVED is a status flag only; priority does not change.
- Config:
  - CFG_WE=1: pending<=CFG_DATA, CFG_PENDING<=1.
  - On a VGA_VS falling edge (registered previous VS=1, current VS=0) with CFG_PENDING=1: CONFIG_COLOURS<=pending, CFG_PENDING<=0.
  - If CFG_WE and the VS falling edge coincide, CFG_DATA goes straight to CONFIG_COLOURS and CFG_PENDING stays 0.
  - Repeated CFG_WE before a frame boundary: the last value wins.
- Address width: no wrap or range checking. Addresses of 19200 and above pass through unchanged.

Test Plan:
- Reset then idle: all outputs at reset values. CONFIG_COLOURS=16'hFF00 and MEM_WE=0 for 10 cycles.
- CPU write then read, no VGA traffic:
  - Write CPU_ADDR=15'd100, CPU_WDATA=1 -> MEM_WE=1 one cycle after grant, CPU_ACK one cycle later.
  - Read of addr 100 -> CPU_ACK with CPU_RDATA=1, 2 cycles after grant.
- VGA_REQ held high 8 cycles at addrs 0..7 (RAM preloaded with alternating 1/0):
  - Required: 8 VALID pulses starting 2 cycles after the first request, data 1,0,1,0,...
  - A CPU_REQ raised at the same time is acknowledged only after VGA_REQ drops.
- Contention: VGA_REQ asserted 1 of every 4 cycles while the CPU issues a read each time.
  - Every CPU read completes in the gaps, and no VGA request is lost or reordered.
- Starvation: VGA_REQ held high 70 cycles with CPU_REQ high -> STARVED=1 after 64 waiting cycles. CPU_ACK follows once VGA_REQ drops; STARVED stays 1 until RESET.
- Config:
  - CFG_WE with 16'hAA00 mid-frame -> CFG_PENDING=1 and CONFIG_COLOURS unchanged.
  - At the next VS falling edge, CONFIG_COLOURS=16'hAA00 and CFG_PENDING=0.
  - RESET asserted during a pending CPU read -> no ACK is ever issued for that read.
